// File: rtl/cache_pkg.sv
// Shared encodings for the key/value cache controller: request ops,
// response status codes and controller states.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_GET     = 2'd0,
    OP_SET     = 2'd1,
    OP_DEL     = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_MISS = 2'd1,
    ST_FULL = 2'd2,
    ST_ERR  = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cache_controller_ttl_clock.sv
// Free-running timestamp, SET expiry adder and wrap-safe expiry comparator.
module ttl_clock #(
  parameter int TTL_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [TTL_WIDTH-1:0] ttl,
  output logic [TTL_WIDTH-1:0] expiry,
  input  logic [TTL_WIDTH-1:0] probe,
  output logic                 expired
);

  logic [TTL_WIDTH-1:0] now_q, now_d;
  logic [TTL_WIDTH-1:0] sum;
  logic [TTL_WIDTH-1:0] age;

  always_comb begin
    now_d = now_q;
    if (tick) now_d = now_q + TTL_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) now_q <= '0;
    else     now_q <= now_d;
  end

  // Expiry 0 means "never"; a sum that wraps onto 0 is nudged to 1.
  assign sum    = now_q + ttl;
  assign expiry = (ttl == '0) ? '0 : ((sum == '0) ? TTL_WIDTH'(1) : sum);

  assign age     = now_q - probe;
  assign expired = (probe != '0) && !age[TTL_WIDTH-1];

endmodule

// File: rtl/cache_controller.sv
// Request sequencer for the cell array: linear key scan with lazy eviction,
// in-place or lowest-free-cell SET, valid bitmap ownership.
module cache_controller
  import cache_pkg::*;
#(
  parameter int NUM_CELLS   = 8,
  parameter int KEY_WIDTH   = 8,
  parameter int VALUE_WIDTH = 64,
  parameter int TTL_WIDTH   = 32,
  parameter int IDX_WIDTH   = $clog2(NUM_CELLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [KEY_WIDTH-1:0]   req_key,
  input  logic [VALUE_WIDTH-1:0] req_value,
  input  logic [TTL_WIDTH-1:0]   req_ttl,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [1:0]             resp_status,
  output logic [VALUE_WIDTH-1:0] resp_value,
  output logic [IDX_WIDTH-1:0]   cell_sel,
  output logic                   cell_read,
  output logic                   cell_write,
  output logic [KEY_WIDTH-1:0]   cell_key_wr,
  output logic [VALUE_WIDTH-1:0] cell_value_wr,
  output logic [TTL_WIDTH-1:0]   cell_ttl_wr,
  input  logic [KEY_WIDTH-1:0]   cell_key_rd,
  input  logic [VALUE_WIDTH-1:0] cell_value_rd,
  input  logic [TTL_WIDTH-1:0]   cell_ttl_rd,
  output logic [NUM_CELLS-1:0]   valid_map
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CELLS - 1);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [TTL_WIDTH-1:0]   ttl_q, ttl_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [IDX_WIDTH-1:0]   free_idx_q, free_idx_d;
  logic                   free_found_q, free_found_d;
  logic [IDX_WIDTH-1:0]   target_q, target_d;
  logic [NUM_CELLS-1:0]   valid_map_q, valid_map_d;
  status_e                resp_status_q, resp_status_d;
  logic [VALUE_WIDTH-1:0] resp_value_q, resp_value_d;

  logic [TTL_WIDTH-1:0]   expiry_wr;
  logic                   cell_expired;
  logic                   cell_valid, cell_live, cell_hit;

  ttl_clock #(.TTL_WIDTH(TTL_WIDTH)) u_ttl_clock (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .ttl     (ttl_q),
    .expiry  (expiry_wr),
    .probe   (cell_ttl_rd),
    .expired (cell_expired)
  );

  assign cell_valid = valid_map_q[idx_q];
  assign cell_live  = cell_valid && !cell_expired;
  assign cell_hit   = cell_live && (cell_key_rd == key_q);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    key_d         = key_q;
    value_d       = value_q;
    ttl_d         = ttl_q;
    idx_d         = idx_q;
    free_idx_d    = free_idx_q;
    free_found_d  = free_found_q;
    target_d      = target_q;
    valid_map_d   = valid_map_q;
    resp_status_d = resp_status_q;
    resp_value_d  = resp_value_q;
    req_ready     = 1'b0;
    cell_sel      = '0;
    cell_read     = 1'b0;
    cell_write    = 1'b0;
    cell_key_wr   = '0;
    cell_value_wr = '0;
    cell_ttl_wr   = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d          = op_e'(req_op);
          key_d         = req_key;
          value_d       = req_value;
          ttl_d         = req_ttl;
          idx_d         = '0;
          free_idx_d    = '0;
          free_found_d  = 1'b0;
          resp_value_d  = '0;
          resp_status_d = ST_OK;
          if (op_e'(req_op) == OP_ILLEGAL) begin
            resp_status_d = ST_ERR;
            state_d       = S_RESP;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        cell_sel  = idx_q;
        cell_read = 1'b1;
        if (cell_valid && cell_expired) valid_map_d[idx_q] = 1'b0;
        if (cell_hit) begin
          state_d = S_RESP;
          unique case (op_q)
            OP_GET: resp_value_d = cell_value_rd;
            OP_DEL: valid_map_d[idx_q] = 1'b0;
            OP_SET: begin
              target_d = idx_q;
              state_d  = S_WRITE;
            end
            default: resp_status_d = ST_ERR;
          endcase
        end else begin
          if (!cell_live && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_RESP;
            if (op_q != OP_SET) begin
              resp_status_d = ST_MISS;
            end else if (free_found_d) begin
              target_d = free_idx_d;
              state_d  = S_WRITE;
            end else begin
              resp_status_d = ST_FULL;
            end
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end

      S_WRITE: begin
        cell_sel              = target_q;
        cell_write            = 1'b1;
        cell_key_wr           = key_q;
        cell_value_wr         = value_q;
        cell_ttl_wr           = expiry_wr;
        valid_map_d[target_q] = 1'b1;
        resp_status_d         = ST_OK;
        state_d               = S_RESP;
      end

      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_GET;
      key_q         <= '0;
      value_q       <= '0;
      ttl_q         <= '0;
      idx_q         <= '0;
      free_idx_q    <= '0;
      free_found_q  <= 1'b0;
      target_q      <= '0;
      valid_map_q   <= '0;
      resp_status_q <= ST_OK;
      resp_value_q  <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      key_q         <= key_d;
      value_q       <= value_d;
      ttl_q         <= ttl_d;
      idx_q         <= idx_d;
      free_idx_q    <= free_idx_d;
      free_found_q  <= free_found_d;
      target_q      <= target_d;
      valid_map_q   <= valid_map_d;
      resp_status_q <= resp_status_d;
      resp_value_q  <= resp_value_d;
    end
  end

  assign resp_valid  = (state_q == S_RESP);
  assign resp_status = resp_status_q;
  assign resp_value  = resp_value_q;
  assign valid_map   = valid_map_q;

endmodule
